i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter that consumes the valid/ready sample stream produced by the wave generators and drives an external I2S DAC. Each accepted `width_p`-bit signed sample is sent once per I2S frame on both left and right channels, MSB-first, left-justified in its slot, with the standard one-bit I2S delay after the word-select edge. The block sits between the tone/mixer path and the board's DAC pins and is the sole consumer of the generator's `ready_i`.

## Interface
- `width_p`, 12, sample width in bits (two's complement).
- `slot_width_p`, 16, bits per channel slot; must satisfy `slot_width_p >= width_p`.
- `clk_div_p`, 4, `clk_i` cycles per half bit-clock period; must be >= 1.

- `clk_i` input 1 system clock; all logic on its rising edge.
- `reset_ni` input 1 reset, synchronous, active-low.
- `valid_i` input 1 upstream sample valid.
- `data_i` input `width_p` upstream sample.
- `ready_o` output 1 holding register empty; a sample transfers when `valid_i & ready_o`.
- `bclk_o` output 1 I2S bit clock.
- `lrclk_o` output 1 I2S word select; 0 = left, 1 = right.
- `sdata_o` output 1 I2S serial data.
- `underrun_o` output 1 one-cycle pulse when a frame starts with no sample held.

## Operation
- Divider counter 0..`clk_div_p`-1; on wrap, `bclk_o` toggles. A 1->0 toggle is a falling-edge event, which advances bit index `b` (0..2S-1, S = `slot_width_p`, wraps 2S-1 -> 0).
- All outputs are registered; `sdata_o` and `lrclk_o` update in the same cycle that `bclk_o` falls.
- `lrclk_o` = 1 for `b` in S-1..2S-2, otherwise 0 (transitions one bit before each slot MSB).
- `sdata_o` at `b` = frame bit `b`. Bits 0..S-1 form the left slot and S..2S-1 the right slot. Each slot is the sample MSB-first followed by S-`width_p` zeros.
- Frame load on the falling edge entering `b`=0:
  - If the holding register is full, copy it into the 2S-bit shift register (sample in both slots) and mark the register empty.
  - If it is empty, load zeros and assert `underrun_o` for that single cycle.
- Holding register: one entry. `ready_o` = !full, registered, and independent of `valid_i`. An accept sets full, and the sample is used at the next frame load.
- Accept and load in the same cycle are impossible when full. When empty at load (underrun), an accept in that same cycle fills the register for the following frame, not the current one.
- Data is never dropped or overwritten while full.

## Timing
- Reset state (`reset_ni`=0 at a rising edge): divider 0, `bclk_o` 0, `b` = 2S-1, `lrclk_o` 0, `sdata_o` 0, `underrun_o` 0, holding empty, `ready_o` 1, shift register 0.
- After reset release, `bclk_o` rises at cycle `clk_div_p`. The first falling edge and frame load (b=0) occur at cycle 2·`clk_div_p`.
- Bit period is 2·`clk_div_p` cycles. Frame period is 4·S·`clk_div_p` cycles (256 at defaults).
- `ready_o` rises 1 cycle after a frame load empties the register and falls 1 cycle after an accept.
- Reset mid-frame aborts immediately to the reset state; a held sample is discarded.

## Structure
- Package `i2s_pkg`: channel encoding constants (`LEFT`=0, `RIGHT`=1) and a function computing frame period from S and `clk_div_p`.
- Sub-module `bclk_gen`: divider plus `bclk_o` register. It emits a one-cycle `fall_o` strobe per falling edge, which the top uses to advance `b` and shift.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Reset release, no valid: `bclk_o` first rises at cycle 4 and falls at cycle 8. `underrun_o` pulses at cycle 8, `sdata_o` stays 0 for the whole frame, and `ready_o` stays 1.
- Offer 12'hABC before the first load: it is accepted, then `ready_o`=0. At cycle 8, `ready_o` returns to 1 one cycle later. The left slot bits are 1010_1011_1100_0000, the right slot is identical, and `lrclk_o` rises at b=15 and falls at b=31.
- Continuous `valid_i` with an incrementing ramp 0,1,2…: exactly one accept per 256 cycles, each frame carries the next value, and there is no underrun.
- Negative sample 12'h800: slot = 1000_0000_0000_0000 in both channels.
- Underrun-cycle accept: hold `valid_i` low until the load cycle, then raise it with 12'h123 in that cycle. The current frame is zeros with an `underrun_o` pulse, and the next frame carries 12'h123.
- Assert `reset_ni`=0 at b=20 with a sample held: all outputs reach reset values on the next edge, and the first frame after release underruns.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter.
//   LEFT / RIGHT : word-select encoding driven on lrclk_o.
//   frame_period : clk_i cycles per I2S frame for a given slot width and
//                  half-bit-clock divider (two slots, two halves per bit).
package i2s_pkg;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    function automatic int frame_period(input int slot_bits, input int clk_div);
        return 4 * slot_bits * clk_div;
    endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// Bit-clock generator for the I2S transmitter.
//   clk_i    : system clock
//   reset_ni : synchronous active-low reset
//   bclk_o   : registered bit clock, toggles every clk_div_p cycles
//   fall_o   : asserted in the cycle whose closing clk_i edge drives bclk_o
//              from 1 to 0, so the caller's registers update on the same
//              edge as the falling bit clock
module bclk_gen #(
    parameter int clk_div_p = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic bclk_o,
    output logic fall_o
);

    localparam int CNT_W = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_div_p - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap   = (cnt_q == CNT_LAST);
    assign fall_o = wrap && bclk_o;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q  <= '0;
            bclk_o <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            bclk_o <= ~bclk_o;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: takes one signed sample per frame from a valid/ready
// stream and sends it MSB-first, left-justified, on both channels with the
// standard one-bit delay after the word-select edge.
//   clk_i      : system clock
//   reset_ni   : synchronous active-low reset
//   valid_i    : upstream sample valid
//   data_i     : upstream sample (two's complement, width_p bits)
//   ready_o    : holding register empty; transfer on valid_i & ready_o
//   bclk_o     : I2S bit clock
//   lrclk_o    : I2S word select (LEFT = 0, RIGHT = 1)
//   sdata_o    : I2S serial data
//   underrun_o : one-cycle pulse when a frame starts with no sample held
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int width_p      = 12,
    parameter int slot_width_p = 16,
    parameter int clk_div_p    = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      valid_i,
    input  logic signed [width_p-1:0] data_i,
    output logic                      ready_o,
    output logic                      bclk_o,
    output logic                      lrclk_o,
    output logic                      sdata_o,
    output logic                      underrun_o
);

    localparam int FRAME_BITS = 2 * slot_width_p;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_BITS - 1);
    // Word select leads each slot MSB by one bit.
    localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(slot_width_p - 1);
    localparam logic [BIT_W-1:0] RIGHT_LAST  = BIT_W'(FRAME_BITS - 2);

    if (slot_width_p < width_p) begin : g_bad_slot
        $error("i2s_tx: slot_width_p must be >= width_p");
    end
    if (clk_div_p < 1) begin : g_bad_div
        $error("i2s_tx: clk_div_p must be >= 1");
    end

    // Left-justify the sample in a slot and duplicate it for both channels.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic signed [width_p-1:0] sample
    );
        logic [slot_width_p-1:0] slot;
        slot = '0;
        slot[slot_width_p-1 -: width_p] = sample;
        return {slot, slot};
    endfunction

    logic                      fall;
    logic                      load;
    logic                      accept;
    logic                      full_q;
    logic signed [width_p-1:0] hold_q;
    logic [BIT_W-1:0]          b_q;
    logic [BIT_W-1:0]          b_next;
    logic [FRAME_BITS-1:0]     shreg_q;
    logic [FRAME_BITS-1:0]     frame_w;

    bclk_gen #(
        .clk_div_p (clk_div_p)
    ) u_bclk_gen (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bclk_o   (bclk_o),
        .fall_o   (fall)
    );

    assign ready_o = !full_q;
    assign accept  = valid_i && !full_q;
    assign load    = fall && (b_q == LAST_BIT);

    always_comb begin
        b_next  = (b_q == LAST_BIT) ? '0 : b_q + 1'b1;
        // An empty holding register at load time sends a silent frame.
        frame_w = full_q ? build_frame(hold_q) : '0;
    end

    // Sample storage: no reset needed, validity is carried by full_q.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            hold_q <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            b_q        <= LAST_BIT;
            lrclk_o    <= LEFT;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
            full_q     <= 1'b0;
            shreg_q    <= '0;
        end else begin
            underrun_o <= 1'b0;
            if (fall) begin
                b_q     <= b_next;
                lrclk_o <= (b_next >= RIGHT_FIRST && b_next <= RIGHT_LAST) ? RIGHT : LEFT;
                if (load) begin
                    // The frame MSB goes straight out; the rest waits in shreg_q.
                    sdata_o    <= frame_w[FRAME_BITS-1];
                    shreg_q    <= frame_w << 1;
                    underrun_o <= !full_q;
                end else begin
                    sdata_o    <= shreg_q[FRAME_BITS-1];
                    shreg_q    <= shreg_q << 1;
                end
            end
            // accept needs an empty register, so it never collides with a
            // load that drains a full one; an accept during an underrun
            // load is kept for the next frame.
            if (accept) begin
                full_q <= 1'b1;
            end else if (load) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int W         = 12;
    localparam int S         = 16;
    localparam int DIV       = 4;
    localparam int FB        = 2 * S;
    localparam int FRAME_CYC = frame_period(S, DIV);

    logic                clk = 1'b0;
    logic                reset_ni = 1'b0;
    logic                valid = 1'b0;
    logic signed [W-1:0] data = '0;
    logic                ready, bclk, lrclk, sdata, underrun;

    i2s_tx #(
        .width_p      (W),
        .slot_width_p (S),
        .clk_div_p    (DIV)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .valid_i    (valid),
        .data_i     (data),
        .ready_o    (ready),
        .bclk_o     (bclk),
        .lrclk_o    (lrclk),
        .sdata_o    (sdata),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int t = 0;
    int exp_b = FB - 1;
    int n_ur = 0;
    int n_acc = 0;
    bit last_acc = 1'b0;
    bit last_fall = 1'b0;
    logic [FB-1:0] sb_q[$];
    logic [FB-1:0] exp_frame = '0;
    logic [FB-1:0] cap = '0;
    logic [FB-1:0] last_cap = '0;
    logic [FB-1:0] lr_cap = '0;
    logic [FB-1:0] last_lr = '0;

    function automatic logic [FB-1:0] frame_of(input logic [W-1:0] d);
        logic [S-1:0] s;
        s = '0;
        s[S-1 -: W] = d;
        return {s, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One clk_i edge with a full reference model of the expected pin state.
    task automatic step();
        bit            acc;
        bit            fall;
        bit            ur;
        logic [FB-1:0] fr;
        logic [4:0]    got;
        logic [4:0]    exp;
        acc = valid && (sb_q.size() == 0);
        fr  = frame_of(data);
        @(posedge clk);
        t++;
        fall = ((t % (2 * DIV)) == 0);
        ur   = 1'b0;
        if (fall) begin
            exp_b = (exp_b == FB - 1) ? 0 : exp_b + 1;
            if (exp_b == 0) begin
                if (sb_q.size() != 0) begin
                    exp_frame = sb_q.pop_front();
                end else begin
                    exp_frame = '0;
                    ur = 1'b1;
                    n_ur++;
                end
            end
        end
        if (acc) begin
            sb_q.push_back(fr);
            n_acc++;
        end
        last_acc  = acc;
        last_fall = fall;
        #1;
        got = {bclk, lrclk, sdata, underrun, ready};
        exp = {(((t / DIV) % 2) == 1),
               (exp_b >= S - 1 && exp_b <= FB - 2),
               exp_frame[FB-1-exp_b],
               ur,
               (sb_q.size() == 0)};
        check("pins{bclk,lr,sd,ur,rdy}", got, exp);
        if (fall) begin
            cap[FB-1-exp_b] = sdata;
            lr_cap[exp_b]   = lrclk;
            if (exp_b == FB - 1) begin
                last_cap = cap;
                last_lr  = lr_cap;
                check("frame", cap, exp_frame);
            end
        end
    endtask

    task automatic run_until_load();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(last_fall && exp_b == 0) && n < 2 * FRAME_CYC);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(last_fall && exp_b == FB - 1) && n < 2 * FRAME_CYC);
    endtask

    task automatic step_ramp();
        step();
        if (last_acc) data = data + 1'b1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        valid    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pins{bclk,lr,sd,ur,rdy}", {bclk, lrclk, sdata, underrun, ready}, 5'b00001);
        @(posedge clk);
        #1;
        reset_ni  = 1'b1;
        t         = 0;
        exp_b     = FB - 1;
        exp_frame = '0;
        cap       = '0;
        sb_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int u0;

        // Idle after reset: bclk timing, underrun at the first load.
        do_reset();
        repeat (3) step();
        check("bclk_t3", bclk, 1'b0);
        step();
        check("bclk_t4", bclk, 1'b1);
        repeat (4) step();
        check("bclk_t8", bclk, 1'b0);
        check("ur_t8", underrun, 1'b1);
        step();
        check("ur_t9", underrun, 1'b0);
        finish_frame();
        check("idle_frame", last_cap, 32'h0);
        check("idle_ready", ready, 1'b1);

        // Sample offered before the first load.
        do_reset();
        valid = 1'b1;
        data  = 12'hABC;
        step();
        check("abc_ready_low", ready, 1'b0);
        valid = 1'b0;
        data  = '0;
        run_until_load();
        check("abc_load_t", t, 8);
        check("abc_ready_back", ready, 1'b1);
        check("abc_no_ur", underrun, 1'b0);
        finish_frame();
        check("abc_frame", last_cap, 32'hABC0_ABC0);
        check("abc_lrclk", last_lr, 32'h7FFF_8000);

        // Continuous ramp: one accept per frame, never an underrun.
        data  = '0;
        valid = 1'b1;
        do begin
            step_ramp();
        end while (!(last_fall && exp_b == 0));
        a0 = n_acc;
        u0 = n_ur;
        repeat (4 * FRAME_CYC) step_ramp();
        check("ramp_accepts", n_acc - a0, 4);
        check("ramp_underruns", n_ur - u0, 0);
        valid = 1'b0;

        // Most negative sample.
        data  = 12'h800;
        valid = 1'b1;
        step();
        valid = 1'b0;
        run_until_load();
        finish_frame();
        check("neg_frame", last_cap, 32'h8000_8000);

        // Accept in the underrun load cycle lands in the following frame.
        while (!((((t + 1) % (2 * DIV)) == 0) && exp_b == FB - 1)) step();
        valid = 1'b1;
        data  = 12'h123;
        step();
        valid = 1'b0;
        check("ura_pulse", underrun, 1'b1);
        check("ura_ready", ready, 1'b0);
        finish_frame();
        check("ura_zero_frame", last_cap, 32'h0);
        run_until_load();
        finish_frame();
        check("ura_next_frame", last_cap, 32'h1230_1230);

        // Reset mid-frame with a sample held discards it.
        run_until_load();
        while (exp_b != 5) step();
        valid = 1'b1;
        data  = 12'h5A5;
        step();
        valid = 1'b0;
        while (exp_b != 20) step();
        check("held_ready", ready, 1'b0);
        do_reset();
        run_until_load();
        check("post_rst_ur", underrun, 1'b1);
        check("post_rst_ready", ready, 1'b1);
        finish_frame();
        check("post_rst_frame", last_cap, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
